text_layer_compositor: RTL and testbench
========================================

// Module: text_layer_compositor
// PURPOSE
//  Parametrised text overlay compositor. Merges NUM_LAYERS text sources (timer, start, crash, finish, ...) into one text_on/text_rgb stream for the pixel mux.
//  Shares a single synchronous font_rom between the layers, selecting by fixed priority.
//  Adds per-layer colours, opaque/transparent mode and refresh-synchronised blinking.
//  Pipelines the font_rom latency so that outputs are registered and glitch-free.
// PARAMETERS
//  NUM_LAYERS   4    number of text layers; layer 0 has the highest priority
//  ROM_ADDR_W   11   font_rom address width
//  RGB_W        12   colour width
//  ROM_LAT      1    font_rom read latency in clk cycles (>=1)
//  BLINK_TICKS  30   refresh_tick count per blink half-period (>=1)
// PORTS
//  clk             in   1                      system clock
//  reset           in   1                      asynchronous, active-low reset
//  refresh_tick    in   1                      one-cycle pulse per video frame
//  layer_on        in   NUM_LAYERS             layer pixel is inside its text region
//  layer_rom_addr  in   NUM_LAYERS*ROM_ADDR_W  per-layer font_rom address; layer i at [i*ROM_ADDR_W +: ROM_ADDR_W]
//  layer_bit_addr  in   NUM_LAYERS*3           per-layer glyph column
//  layer_fg        in   NUM_LAYERS*RGB_W       per-layer glyph colour
//  layer_bg        in   NUM_LAYERS*RGB_W       per-layer background colour; used only when opaque
//  layer_opaque    in   NUM_LAYERS             1 = fill the region with bg; 0 = glyph pixels only
//  layer_blink     in   NUM_LAYERS             1 = layer participates in blinking
//  rom_addr        out  ROM_ADDR_W             address to font_rom (combinational)
//  font_word       in   8                      font_rom data, ROM_LAT cycles after rom_addr
//  text_on         out  1                      composited text pixel is active (registered)
//  text_rgb        out  RGB_W                  composited colour (registered)
// BEHAVIOUR
//  Reset (reset=0, async):
//   - pipeline valid bits cleared; text_on=0, text_rgb=0
//   - blink_cnt=0; blink_phase=1 (visible)
//  Blink timer:
//   - blink_cnt increments on each refresh_tick.
//   - On the tick where blink_cnt==BLINK_TICKS-1, blink_cnt wraps to 0 and blink_phase toggles.
//   - No change occurs without a refresh_tick.
//  Stage S0 (combinational select):
//   - eff_on[i] = layer_on[i] & ~(layer_blink[i] & ~blink_phase).
//   - Winner = lowest index i with eff_on[i]=1.
//   - rom_addr = layer_rom_addr of the winner; rom_addr = 0 when there is no winner.
//   - A blanked layer is treated as absent, so a lower-priority layer wins instead.
//  Stages S1..S(ROM_LAT):
//   - Register valid, winner's bit_addr, fg, bg and opaque so they align with font_word.
//  Output stage (one register):
//   - font_bit = font_word[7 - bit_addr], so column 0 is the MSB.
//   - valid & opaque:                 text_on=1, text_rgb = font_bit ? fg : bg
//   - valid & ~opaque & font_bit:     text_on=1, text_rgb = fg
//   - otherwise:                      text_on=0, text_rgb = 0
//   - There is no fall-through to a lower layer on a transparent zero bit: only one ROM fetch is made per pixel.
//  Latency:
//   - text_on/text_rgb reflect the pix inputs of cycle t at cycle t+ROM_LAT+1.
//   - The parent delays hsync/vsync/video_on by ROM_LAT+1 cycles.
//  Throughput: one pixel per clk; no stalls; no handshake.
//  Simultaneous events:
//   - A refresh_tick in the same cycle as a layer change: S0 uses the pre-toggle blink_phase.
//   - The toggle is visible from the next cycle.
//  Reset mid-frame: in-flight pixels are dropped (outputs 0); normal output resumes ROM_LAT+1 cycles after release.
//  All outputs are fully assigned on every path: no latches, no X when no layer is active.
// TESTING
//  1. Reset: hold reset=0 with layer_on=all ones -> text_on=0, text_rgb=0; after release, first valid output appears at cycle ROM_LAT+1.
//  2. Priority: layer_on=4'b0110, layer1 addr=0x041, layer2 addr=0x052 -> rom_addr=0x041; layer1 fg on glyph bits; layer2 never shown.
//  3. Opaque layer0 (fg=12'h001, bg=12'h110), font_word=8'b1000_0000: bit_addr=0 -> rgb=12'h001; bit_addr=1 -> rgb=12'h110; text_on=1 both.
//  4. Transparent layer3 (fg=12'h501), font_word=8'h18: bit_addr=3 -> text_on=1, rgb=12'h501; bit_addr=0 -> text_on=0, rgb=0.
//  5. Blink, BLINK_TICKS=2, layer0 blink with layer1 also on: 2 refresh_ticks -> layer1 shown; 2 more -> layer0 back; tick+layer change in same cycle uses the old phase.
//  6. Reset asserted mid-stream after 5 active pixels -> text_on drops to 0 asynchronously; blink_cnt=0, blink_phase=1.

Source files
------------

// File: rtl/text_layer_compositor.sv
// Purpose: composite NUM_LAYERS text sources into one text pixel via a single shared font_rom.
// Latency: ROM_LAT+1 clk cycles from layer inputs to registered text_on/text_rgb.
// Backpressure: none; one pixel per clk, no stalls and no handshake.
module text_layer_compositor #(
    parameter int NUM_LAYERS  = 4,
    parameter int ROM_ADDR_W  = 11,
    parameter int RGB_W       = 12,
    parameter int ROM_LAT     = 1,
    parameter int BLINK_TICKS = 30
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             refresh_tick,
    input  logic [NUM_LAYERS-1:0]            layer_on,
    input  logic [NUM_LAYERS*ROM_ADDR_W-1:0] layer_rom_addr,
    input  logic [NUM_LAYERS*3-1:0]          layer_bit_addr,
    input  logic [NUM_LAYERS*RGB_W-1:0]      layer_fg,
    input  logic [NUM_LAYERS*RGB_W-1:0]      layer_bg,
    input  logic [NUM_LAYERS-1:0]            layer_opaque,
    input  logic [NUM_LAYERS-1:0]            layer_blink,
    output logic [ROM_ADDR_W-1:0]            rom_addr,
    input  logic [7:0]                       font_word,
    output logic                             text_on,
    output logic [RGB_W-1:0]                 text_rgb
);

    localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [CNT_W-1:0]      blink_cnt;
    logic                  blink_phase;

    logic [NUM_LAYERS-1:0] eff_on;
    logic                  sel_vld;
    logic [2:0]            sel_col;
    logic [RGB_W-1:0]      sel_fg;
    logic [RGB_W-1:0]      sel_bg;
    logic                  sel_opq;

    // Attributes of the winning layer, delayed to line up with font_word.
    logic                  pipe_vld [ROM_LAT];
    logic [2:0]            pipe_col [ROM_LAT];
    logic [RGB_W-1:0]      pipe_fg  [ROM_LAT];
    logic [RGB_W-1:0]      pipe_bg  [ROM_LAT];
    logic                  pipe_opq [ROM_LAT];

    logic                  font_bit;
    logic                  next_on;
    logic [RGB_W-1:0]      next_rgb;

    // Blink timer: phase flips every BLINK_TICKS frames, starting visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (refresh_tick) begin
            if (blink_cnt == CNT_W'(BLINK_TICKS - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
            end
        end
    end

    // S0: blanked layers drop out, lowest-index active layer drives the ROM.
    always_comb begin
        eff_on   = layer_on & ~(layer_blink & {NUM_LAYERS{~blink_phase}});
        sel_vld  = 1'b0;
        rom_addr = '0;
        sel_col  = '0;
        sel_fg   = '0;
        sel_bg   = '0;
        sel_opq  = 1'b0;
        // Descending scan so the lowest active index is the last to assign.
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eff_on[i]) begin
                sel_vld  = 1'b1;
                rom_addr = layer_rom_addr[i*ROM_ADDR_W +: ROM_ADDR_W];
                sel_col  = layer_bit_addr[i*3 +: 3];
                sel_fg   = layer_fg[i*RGB_W +: RGB_W];
                sel_bg   = layer_bg[i*RGB_W +: RGB_W];
                sel_opq  = layer_opaque[i];
            end
        end
    end

    // S1..S(ROM_LAT): shift the winner's attributes alongside the ROM read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < ROM_LAT; k++) begin
                pipe_vld[k] <= 1'b0;
                pipe_col[k] <= '0;
                pipe_fg[k]  <= '0;
                pipe_bg[k]  <= '0;
                pipe_opq[k] <= 1'b0;
            end
        end else begin
            pipe_vld[0] <= sel_vld;
            pipe_col[0] <= sel_col;
            pipe_fg[0]  <= sel_fg;
            pipe_bg[0]  <= sel_bg;
            pipe_opq[0] <= sel_opq;
            for (int k = 1; k < ROM_LAT; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_col[k] <= pipe_col[k-1];
                pipe_fg[k]  <= pipe_fg[k-1];
                pipe_bg[k]  <= pipe_bg[k-1];
                pipe_opq[k] <= pipe_opq[k-1];
            end
        end
    end

    // Output decode: column 0 is the glyph MSB; transparent zero bits show nothing.
    always_comb begin
        font_bit = font_word[3'd7 - pipe_col[ROM_LAT-1]];
        next_on  = 1'b0;
        next_rgb = '0;
        if (pipe_vld[ROM_LAT-1]) begin
            if (pipe_opq[ROM_LAT-1]) begin
                next_on  = 1'b1;
                next_rgb = font_bit ? pipe_fg[ROM_LAT-1] : pipe_bg[ROM_LAT-1];
            end else if (font_bit) begin
                next_on  = 1'b1;
                next_rgb = pipe_fg[ROM_LAT-1];
            end
        end
    end

    // Output register keeps text_on/text_rgb glitch-free for the pixel mux.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            text_on  <= 1'b0;
            text_rgb <= '0;
        end else begin
            text_on  <= next_on;
            text_rgb <= next_rgb;
        end
    end

endmodule

// File: tb/tb_text_layer_compositor.sv
module tb_text_layer_compositor;

    localparam int NL  = 4;
    localparam int AW  = 11;
    localparam int RW  = 12;
    localparam int LAT = 2;
    localparam int BT  = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               refresh_tick = 1'b0;
    logic [NL-1:0]      layer_on = '0;
    logic [NL*AW-1:0]   layer_rom_addr = '0;
    logic [NL*3-1:0]    layer_bit_addr = '0;
    logic [NL*RW-1:0]   layer_fg = '0;
    logic [NL*RW-1:0]   layer_bg = '0;
    logic [NL-1:0]      layer_opaque = '0;
    logic [NL-1:0]      layer_blink = '0;
    logic [AW-1:0]      rom_addr;
    logic [7:0]         font_word;
    logic               text_on;
    logic [RW-1:0]      text_rgb;

    text_layer_compositor #(
        .NUM_LAYERS(NL), .ROM_ADDR_W(AW), .RGB_W(RW), .ROM_LAT(LAT), .BLINK_TICKS(BT)
    ) dut (
        .clk(clk), .reset(reset), .refresh_tick(refresh_tick),
        .layer_on(layer_on), .layer_rom_addr(layer_rom_addr), .layer_bit_addr(layer_bit_addr),
        .layer_fg(layer_fg), .layer_bg(layer_bg), .layer_opaque(layer_opaque),
        .layer_blink(layer_blink), .rom_addr(rom_addr), .font_word(font_word),
        .text_on(text_on), .text_rgb(text_rgb)
    );

    always #5 clk = ~clk;

    // Font ROM contents: two fixed glyph rows for directed cases, hash elsewhere.
    function automatic logic [7:0] rom_fn(input logic [AW-1:0] a);
        int h;
        if (a == 11'h100) return 8'h80;
        if (a == 11'h200) return 8'h18;
        h = int'(a) * 37 + 11 + (int'(a) >> 3);
        return h[7:0];
    endfunction

    // Synchronous ROM with LAT cycles of latency.
    logic [7:0] rom_pipe [LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_fn(rom_addr);
        for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign font_word = rom_pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic          on;
        logic [RW-1:0] rgb;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Stimulus state and reference-model state.
    logic [AW-1:0] t_addr [NL];
    logic [2:0]    t_col  [NL];
    logic [RW-1:0] t_fg   [NL];
    logic [RW-1:0] t_bg   [NL];
    logic [NL-1:0] t_on, t_opq, t_blink;
    int            ticks = 0;
    logic          pending_release = 1'b0;

    // Monitor: compare each registered output against the entry due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (reset && sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.due != cyc || text_on !== e.on || text_rgb !== e.rgb) begin
                    errors++;
                    $display("FAIL pixel cyc=%0d due=%0d: got on=%b rgb=%h, want on=%b rgb=%h",
                             cyc, e.due, text_on, text_rgb, e.on, e.rgb);
                end
            end
        end
    end

    // One pixel: drive inputs, compute the expected pixel from the rules, push it.
    task automatic pixel(input logic tick);
        logic          visible;
        int            win;
        logic [AW-1:0] ea;
        logic [7:0]    fw;
        logic          fb;
        exp_t          e;
        @(negedge clk);
        if (pending_release) begin
            reset = 1'b1;
            pending_release = 1'b0;
        end
        for (int i = 0; i < NL; i++) begin
            layer_rom_addr[i*AW +: AW] = t_addr[i];
            layer_bit_addr[i*3 +: 3]   = t_col[i];
            layer_fg[i*RW +: RW]       = t_fg[i];
            layer_bg[i*RW +: RW]       = t_bg[i];
        end
        layer_on     = t_on;
        layer_opaque = t_opq;
        layer_blink  = t_blink;
        refresh_tick = tick;

        visible = ((ticks / BT) % 2) == 0;
        win = -1;
        for (int i = 0; i < NL; i++)
            if (win < 0 && t_on[i] && !(t_blink[i] && !visible)) win = i;
        e.due = cyc + LAT + 1;
        e.on  = 1'b0;
        e.rgb = '0;
        ea    = '0;
        if (win >= 0) begin
            ea = t_addr[win];
            fw = rom_fn(ea);
            fb = fw[7 - int'(t_col[win])];
            if (t_opq[win]) begin
                e.on  = 1'b1;
                e.rgb = fb ? t_fg[win] : t_bg[win];
            end else if (fb) begin
                e.on  = 1'b1;
                e.rgb = t_fg[win];
            end
        end
        sb.push_back(e);
        if (tick) ticks++;

        #1;
        checks++;
        if (rom_addr !== ea) begin
            errors++;
            $display("FAIL rom_addr cyc=%0d: got %h, want %h", cyc, rom_addr, ea);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (text_on !== 1'b0 || text_rgb !== '0) begin
            errors++;
            $display("FAIL %s: got on=%b rgb=%h, want on=0 rgb=000", name, text_on, text_rgb);
        end
    endtask

    // Hold reset for a few cycles, then release on the next driven pixel.
    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            check_idle("reset_hold");
        end
        ticks = 0;
        pending_release = 1'b1;
    endtask

    task automatic clear_layers();
        for (int i = 0; i < NL; i++) begin
            t_addr[i] = '0; t_col[i] = '0; t_fg[i] = '0; t_bg[i] = '0;
        end
        t_on = '0; t_opq = '0; t_blink = '0;
    endtask

    initial begin
        clear_layers();

        // Reset with every layer requesting the pixel.
        t_on = '1; t_opq = '1;
        for (int i = 0; i < NL; i++) begin
            t_addr[i] = 11'h100; t_fg[i] = RW'(i + 1); t_bg[i] = 12'hABC;
        end
        layer_on = '1; layer_opaque = '1;
        hold_reset(4);
        for (int i = 0; i < 4; i++) pixel(1'b0);

        // Priority: layers 1 and 2 on, layer 1 transparent, sweep its columns.
        clear_layers();
        t_on = 4'b0110;
        t_addr[1] = 11'h041; t_fg[1] = 12'h0F0;
        t_addr[2] = 11'h052; t_fg[2] = 12'hF00; t_opq[2] = 1'b1; t_bg[2] = 12'h00F;
        for (int c = 0; c < 8; c++) begin
            t_col[1] = 3'(c);
            pixel(1'b0);
        end

        // Opaque layer 0 on glyph 1000_0000.
        clear_layers();
        t_on = 4'b0001; t_opq = 4'b0001;
        t_addr[0] = 11'h100; t_fg[0] = 12'h001; t_bg[0] = 12'h110;
        t_col[0] = 3'd0; pixel(1'b0);
        t_col[0] = 3'd1; pixel(1'b0);

        // Transparent layer 3 on glyph 0x18.
        clear_layers();
        t_on = 4'b1000;
        t_addr[3] = 11'h200; t_fg[3] = 12'h501;
        t_col[3] = 3'd3; pixel(1'b0);
        t_col[3] = 3'd0; pixel(1'b0);

        // Blink: layer 0 blinks over opaque layer 1.
        clear_layers();
        t_on = 4'b0011; t_blink = 4'b0001; t_opq = 4'b0011;
        t_addr[0] = 11'h100; t_fg[0] = 12'h111; t_bg[0] = 12'h222;
        t_addr[1] = 11'h0A5; t_fg[1] = 12'h333; t_bg[1] = 12'h444;
        pixel(1'b1); pixel(1'b0); pixel(1'b1);
        for (int i = 0; i < 3; i++) pixel(1'b0);
        pixel(1'b1); pixel(1'b0);
        t_col[0] = 3'd2; t_col[1] = 3'd5;
        pixel(1'b1);
        t_on = 4'b0001;
        pixel(1'b1);
        for (int i = 0; i < 3; i++) pixel(1'b0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NL; i++) begin
                t_addr[i] = AW'($urandom);
                t_col[i]  = 3'($urandom);
                t_fg[i]   = RW'($urandom);
                t_bg[i]   = RW'($urandom);
            end
            t_on    = NL'($urandom);
            t_opq   = NL'($urandom);
            t_blink = NL'($urandom);
            pixel($urandom_range(0, 4) == 0);
        end

        // Asynchronous reset after five opaque pixels are in flight.
        clear_layers();
        t_on = 4'b0001; t_opq = 4'b0001;
        t_addr[0] = 11'h100; t_fg[0] = 12'hFED; t_bg[0] = 12'h0C0;
        for (int i = 0; i < 5; i++) pixel(1'b1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        check_idle("async_reset_drop");
        hold_reset(2);
        t_blink = 4'b0001;
        pixel(1'b1);
        for (int i = 0; i < 4; i++) pixel(1'b0);
        pixel(1'b1);
        for (int i = 0; i < 4; i++) pixel(1'b0);

        // Drain outstanding expectations.
        clear_layers();
        for (int i = 0; i < LAT + 3; i++) pixel(1'b0);
        repeat (LAT + 3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected pixels never compared, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
